// File: rtl/fpexc_lanes.sv
// fpexc_lanes: multi-lane FPU exception unit.
// Classifies operands/result per lane, drives result-manipulation controls and
// IEEE flags through one elastic register stage, and folds raised flags into a
// sticky fflags register on each output handshake.
// Optional build macro FPEXC_CNT_EN adds saturating per-flag event counters
// (CNT_W parameter and Cnt_DO port exist only in that build).
module fpexc_lanes #(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned MANT_W    = 23,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned CMD_W     = 4
`ifdef FPEXC_CNT_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic                                 Clk_CI,
  input  logic                                 Rst_RBI,
  input  logic                                 In_valid_SI,
  output logic                                 In_ready_SO,
  input  logic [CMD_W-1:0]                     Op_SI,
  input  logic [NUM_LANES-1:0]                 Lane_en_SI,
  input  logic [NUM_LANES-1:0][MANT_W:0]       Mant_a_DI,
  input  logic [NUM_LANES-1:0][MANT_W:0]       Mant_b_DI,
  input  logic [NUM_LANES-1:0][EXP_W-1:0]      Exp_a_DI,
  input  logic [NUM_LANES-1:0][EXP_W-1:0]      Exp_b_DI,
  input  logic [NUM_LANES-1:0]                 Sign_a_DI,
  input  logic [NUM_LANES-1:0]                 Sign_b_DI,
  input  logic [NUM_LANES-1:0][MANT_W:0]       Mant_norm_DI,
  input  logic [NUM_LANES-1:0]                 Mant_rounded_SI,
  input  logic [NUM_LANES-1:0]                 Exp_OF_SI,
  input  logic [NUM_LANES-1:0]                 Exp_UF_SI,
  input  logic [NUM_LANES-1:0]                 OF_SI,
  input  logic [NUM_LANES-1:0]                 UF_SI,
  input  logic [NUM_LANES-1:0]                 Zero_SI,
  input  logic [NUM_LANES-1:0]                 IX_SI,
  input  logic [NUM_LANES-1:0]                 IV_SI,
  input  logic [NUM_LANES-1:0]                 Inf_SI,
  output logic                                 Out_valid_SO,
  input  logic                                 Out_ready_SI,
  output logic [NUM_LANES-1:0]                 Exp_toZero_SO,
  output logic [NUM_LANES-1:0]                 Exp_toInf_SO,
  output logic [NUM_LANES-1:0]                 Mant_toZero_SO,
  output logic [NUM_LANES-1:0]                 OF_SO,
  output logic [NUM_LANES-1:0]                 UF_SO,
  output logic [NUM_LANES-1:0]                 Zero_SO,
  output logic [NUM_LANES-1:0]                 IX_SO,
  output logic [NUM_LANES-1:0]                 IV_SO,
  output logic [NUM_LANES-1:0]                 Inf_SO,
  input  logic                                 Flags_wr_SI,
  input  logic [3:0]                           Flags_DI,
  input  logic                                 Flags_clr_SI,
  output logic [3:0]                           Flags_DO
`ifdef FPEXC_CNT_EN
  ,
  output logic [3:0][CNT_W-1:0]                Cnt_DO
`endif
);

  // fpu_defs opcode encodings
  localparam logic [CMD_W-1:0] C_FPU_ADD_CMD = CMD_W'(0);
  localparam logic [CMD_W-1:0] C_FPU_SUB_CMD = CMD_W'(1);
  localparam logic [CMD_W-1:0] C_FPU_MUL_CMD = CMD_W'(2);
  localparam logic [CMD_W-1:0] C_FPU_I2F_CMD = CMD_W'(4);
  localparam logic [CMD_W-1:0] C_FPU_F2I_CMD = CMD_W'(5);

  typedef struct packed {
    logic exp_to_zero;
    logic exp_to_inf;
    logic mant_to_zero;
    logic of;
    logic uf;
    logic zero;
    logic ix;
    logic iv;
    logic inf;
  } lane_res_t;

  lane_res_t [NUM_LANES-1:0] res_d;
  lane_res_t [NUM_LANES-1:0] res_q;
  logic                      out_valid_q;
  logic                      accept;
  logic                      out_hs;
  logic [3:0]                acc;
  logic [3:0]                flags_q;
  logic [3:0]                flags_d;

  logic is_addsub, is_mul, is_i2f, is_f2i;

  // Opcode decode shared by all lanes
  always_comb begin
    is_addsub = (Op_SI == C_FPU_ADD_CMD) || (Op_SI == C_FPU_SUB_CMD);
    is_mul    = (Op_SI == C_FPU_MUL_CMD);
    is_i2f    = (Op_SI == C_FPU_I2F_CMD);
    is_f2i    = (Op_SI == C_FPU_F2I_CMD);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic inf_a, inf_b, zero_a, zero_b, mz, sdiff;
    logic iv, of, uf, zero, ix, inf, inf_t, eti, etz;

    // Per-lane classification and flag/control generation
    always_comb begin
      inf_a  = &Exp_a_DI[g];
      inf_b  = &Exp_b_DI[g];
      zero_a = (Exp_a_DI[g] == '0) && (Mant_a_DI[g] == '0);
      zero_b = (Exp_b_DI[g] == '0) && (Mant_b_DI[g] == '0);
      mz     = (Mant_norm_DI[g] == '0);
      sdiff  = Sign_a_DI[g] ^ Sign_b_DI[g];
      iv     = 1'b0;
      inf_t  = 1'b0;
      if (is_addsub) begin
        iv    = inf_a & inf_b & sdiff;
        inf_t = (inf_a ^ inf_b) | (inf_a & inf_b & ~sdiff);
      end else if (is_mul) begin
        iv    = (inf_a & zero_b) | (inf_b & zero_a);
        inf_t = (inf_a & ~zero_b) | (inf_b & ~zero_a);
      end
      if (is_f2i) begin
        iv   = IV_SI[g];
        of   = OF_SI[g];
        uf   = UF_SI[g];
        zero = Zero_SI[g];
        ix   = IX_SI[g];
        inf  = Inf_SI[g];
      end else begin
        of   = (Exp_OF_SI[g] & ~mz) | (~iv & (inf_a ^ inf_b) & ~is_i2f);
        uf   = Exp_UF_SI[g] & Mant_rounded_SI[g];
        zero = mz & ~iv;
        ix   = Mant_rounded_SI[g] | of;
        inf  = inf_t | (Exp_OF_SI[g] & ~mz);
      end
      eti = of | iv;
      etz = is_i2f ? (zero_a & ~Sign_a_DI[g]) : (Exp_UF_SI[g] | (mz & ~eti));
      res_d[g] = '0;
      if (Lane_en_SI[g]) begin
        res_d[g] = '{exp_to_zero: etz, exp_to_inf: eti, mant_to_zero: inf,
                     of: of, uf: uf, zero: zero, ix: ix, iv: iv, inf: inf};
      end
    end

    assign Exp_toZero_SO[g]  = res_q[g].exp_to_zero;
    assign Exp_toInf_SO[g]   = res_q[g].exp_to_inf;
    assign Mant_toZero_SO[g] = res_q[g].mant_to_zero;
    assign OF_SO[g]          = res_q[g].of;
    assign UF_SO[g]          = res_q[g].uf;
    assign Zero_SO[g]        = res_q[g].zero;
    assign IX_SO[g]          = res_q[g].ix;
    assign IV_SO[g]          = res_q[g].iv;
    assign Inf_SO[g]         = res_q[g].inf;
  end

  assign In_ready_SO  = ~out_valid_q | Out_ready_SI;
  assign accept       = In_valid_SI & In_ready_SO;
  assign out_hs       = out_valid_q & Out_ready_SI;
  assign Out_valid_SO = out_valid_q;

  // Elastic output stage: load on accept, empty on handshake without refill
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      res_q       <= res_d;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  // Flags raised by the beat leaving the stage; disabled lanes are already zero
  always_comb begin
    acc = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      acc |= {res_q[l].iv, res_q[l].of, res_q[l].uf, res_q[l].ix};
    end
    if (!out_hs) acc = '0;
  end

  // Write beats clear; a same-cycle event is OR'ed in after either
  always_comb begin
    flags_d = flags_q;
    if (Flags_wr_SI)       flags_d = Flags_DI;
    else if (Flags_clr_SI) flags_d = '0;
    flags_d |= acc;
  end

  // Sticky flag register
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) flags_q <= '0;
    else          flags_q <= flags_d;
  end

  assign Flags_DO = flags_q;

`ifdef FPEXC_CNT_EN
  logic [3:0][CNT_W-1:0] cnt_q;

  // Saturating per-flag event counters; clear wins over increment
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI || Flags_clr_SI) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign Cnt_DO = cnt_q;
`else
`endif

endmodule
